// File: rtl/mem_defs_pkg.sv
// Shared memory-system definitions: line geometry, default latency and FSM state codes.
// cache_controller imports the same constants so both sides agree on the line format.
package mem_defs;

  localparam int LINE_W      = 64;
  localparam int LINE_ADDR_W = 14;
  localparam int MEM_LATENCY = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W line storage: synchronous write, combinational read on a single address.
module mem_array #(
  parameter int DEPTH  = 16384,
  parameter int DATA_W = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing 2**ADDR_W lines would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/unified_mem.sv
// Fixed-latency unified line memory behind the cache controller's m_* port.
// Owns the request FSM, the latency counter and the latched request; mem_array holds the data.
module unified_mem
  import mem_defs::*;
#(
  parameter int ADDR_W  = LINE_ADDR_W,
  parameter int DATA_W  = LINE_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy
);

  logic [1:0]        state;
  logic [3:0]        cnt;
  mem_op_e           lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  // Write commits on the DONE->IDLE edge, so a following read always sees it.
  assign mem_we = (state == ST_DONE) && (lat_op == OP_WRITE);
  assign rdy    = (state == ST_DONE);

  mem_array #(
    .DEPTH  (2 ** ADDR_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (lat_addr),
    .wdata (lat_data),
    .rdata (mem_rdata)
  );

  // NOTE: all state here uses <= so every branch sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_op   <= OP_READ;
      lat_addr <= '0;
      lat_data <= '0;
      rd_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (we || re) begin
            lat_addr <= addr;
            lat_data <= wr_data;
            lat_op   <= we ? OP_WRITE : OP_READ;
            cnt      <= 4'(LATENCY - 2);
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            state <= ST_DONE;
            if (lat_op == OP_READ) rd_data <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
